multiplier_arbiter: RTL and testbench
=====================================

Name: multiplier_arbiter

Overview:
- Shares one fsm_multiplier instance between NUM_REQ requesters; each requester streams one full n/m operand pair per job.
- Round-robin arbitration, issued only when the multiplier reports ready.
- Forwards the granted requester's operand blocks to the multiplier, then routes the 2*BLOCKS-block product stream back to that requester only.
- Sits between the encryption/modexp engines and the multiplier.

Parameters:
REGISTER_SIZE, 32, width of one data block.
BITS_IN_NUM, 4096, operand width in bits; BLOCKS = BITS_IN_NUM/REGISTER_SIZE = 128.
NUM_REQ, 4, number of requesters (>=2).

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset; synchronous, active-high; also drives the multiplier's rst_in
req_in  in  NUM_REQ  requester i wants a product
n_in  in  NUM_REQ*REGISTER_SIZE  packed n blocks, requester i at [i*RS +: RS]
m_in  in  NUM_REQ*REGISTER_SIZE  packed m blocks, same packing
blk_valid_in  in  NUM_REQ  n/m block of requester i valid this cycle
grant_out  out  NUM_REQ  one-hot grant; requester may present blocks only while granted
mul_n_out  out  REGISTER_SIZE  to multiplier n_in
mul_m_out  out  REGISTER_SIZE  to multiplier m_in
mul_valid_out  out  1  to multiplier valid_in
mul_ready_in  in  1  multiplier ready_out
mul_data_in  in  REGISTER_SIZE  multiplier data_out
mul_valid_in  in  1  multiplier valid_out
mul_final_in  in  1  multiplier final_out
data_out  out  REGISTER_SIZE  product block, shared by all requesters
valid_out  out  NUM_REQ  one-hot: data_out valid for requester i
final_out  out  NUM_REQ  one-hot: last product beat for requester i
busy_out  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, grant_out=0, mul_valid_out=0, mul_n_out=0, mul_m_out=0, data_out=0, valid_out=0, final_out=0, rr pointer=0, block count=0. Reset mid-job aborts the job with no final_out. The multiplier is reset on the same edge.
- State machine: IDLE -> FEED -> WAIT_RESULT -> IDLE.
- IDLE:
  - Arbitrates when any req_in bit is set and mul_ready_in=1.
  - Winner is the first set bit scanning from rr_ptr+1, wrapping at NUM_REQ.
  - Next cycle: grant_out=onehot(winner), state=FEED, block count=0.
  - If mul_ready_in=0, no grant is issued; requests stay pending.
- FEED:
  - Every cycle, registered forward: mul_n_out/mul_m_out <= selected slice, mul_valid_out <= blk_valid_in[g]. Latency is 1 cycle.
  - Gaps in blk_valid_in are allowed; mul_valid_out is low during a gap and the multiplier stalls.
  - Count increments on each accepted block.
  - On the BLOCKS-th accepted block: grant_out <= 0, state=WAIT_RESULT. mul_valid_out drops the cycle after the last block is forwarded.
  - blk_valid_in from non-granted requesters is ignored.
  - Deassertion of req_in[g] during FEED is ignored; the job completes.
- WAIT_RESULT:
  - Registered 1 cycle: data_out <= mul_data_in, valid_out <= mul_valid_in<<g, final_out <= mul_final_in<<g.
  - When mul_final_in=1, state=IDLE and rr_ptr=g.
  - Requesters must tolerate valid_out beats beyond 2*BLOCKS; final_out is authoritative.
- Next job: a new grant needs mul_ready_in=1 again. The earliest new grant is 1 cycle after return to IDLE.
- Simultaneous req_in and final: the request is arbitrated in IDLE on the next cycle, never in the same cycle as the final.
- Width rule: n_in/m_in slices are indexed with a $clog2(NUM_REQ)-bit grant index.
- Data path: no arithmetic; pure mux plus registers.
- Starvation bound: worst case NUM_REQ-1 jobs wait.

Decomposition:
- Package mult_arb_pkg:
  - arb_state_t enum {IDLE, FEED, WAIT_RESULT};
  - BLOCKS and COUNT_WIDTH = $clog2(BLOCKS+1) derivation functions;
  - one-hot/index conversion function.
- Sub-module rr_picker (NUM_REQ; inputs req, ptr; outputs one-hot winner and index). Purely combinational; used inside the arbiter FSM.

Test Plan:
1. Requester 0 only; n block0=3, m block0=5, rest 0 → grant_out=4'b0001. Result on requester 0: block0=15, blocks 1..255=0, then final_out[0]; valid_out[1..3] stay 0.
2. req_in=4'b0110 asserted together, rr_ptr=0 → grant order 1 then 2. Then req_in=4'b0011 → grant 0, then 1.
3. All four requesting continuously for 8 jobs → grant sequence 0,1,2,3,0,1,2,3; each product (n=i+2, m=7) returns 7*(i+2) in block0 on the matching valid_out bit.
4. Granted requester inserts a 10-cycle blk_valid_in gap after block 50; n=m=2^4096-1 → product blocks 0=1, 1..127=0, 128=0xFFFFFFFE, 129..255=0xFFFFFFFF.
5. rst_in pulsed at block 60 of FEED → next cycle all outputs 0 and state IDLE, no final_out. A fresh job afterwards produces a correct 15.
6. mul_ready_in held 0 with req_in=4'b1000 → no grant; ready rises at cycle 20 → grant_out=4'b1000 at cycle 21.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// ============================================================================
// mult_arb_pkg : shared types and helper functions for multiplier_arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FEED        = 2'd1,
        WAIT_RESULT = 2'd2
    } arb_state_t;

    function automatic int calc_blocks(input int bits, input int reg_size);
        return bits / reg_size;
    endfunction

    function automatic int calc_count_width(input int blocks);
        return $clog2(blocks + 1);
    endfunction

    function automatic int onehot_index(input logic [31:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multiplier_arbiter_rr_picker.sv
// ============================================================================
// rr_picker : combinational round-robin pick, scanning upward from ptr+1
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        // ptr itself is visited last, so the previous owner has lowest priority
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                  = 1'b1;
                winner[pos[IDX_W-1:0]] = 1'b1;
            end
        end
        index = IDX_W'(onehot_index(32'(winner)));
    end

endmodule

`default_nettype wire

// File: rtl/multiplier_arbiter.sv
// ============================================================================
// multiplier_arbiter : round-robin sharing of one block-serial multiplier
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_arbiter
    import mult_arb_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096,
    parameter int NUM_REQ       = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_REQ-1:0]                 req_in,
    input  logic [NUM_REQ*REGISTER_SIZE-1:0]   n_in,
    input  logic [NUM_REQ*REGISTER_SIZE-1:0]   m_in,
    input  logic [NUM_REQ-1:0]                 blk_valid_in,
    output logic [NUM_REQ-1:0]                 grant_out,
    output logic [REGISTER_SIZE-1:0]           mul_n_out,
    output logic [REGISTER_SIZE-1:0]           mul_m_out,
    output logic                               mul_valid_out,
    input  logic                               mul_ready_in,
    input  logic [REGISTER_SIZE-1:0]           mul_data_in,
    input  logic                               mul_valid_in,
    input  logic                               mul_final_in,
    output logic [REGISTER_SIZE-1:0]           data_out,
    output logic [NUM_REQ-1:0]                 valid_out,
    output logic [NUM_REQ-1:0]                 final_out,
    output logic                               busy_out
);

    localparam int BLOCKS      = calc_blocks(BITS_IN_NUM, REGISTER_SIZE);
    localparam int COUNT_WIDTH = calc_count_width(BLOCKS);
    localparam int IDX_W       = $clog2(NUM_REQ);

    arb_state_t             state;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       rr_ptr;
    logic [COUNT_WIDTH-1:0] blk_count;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]       pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req    (req_in),
        .ptr    (rr_ptr),
        .winner (pick_onehot),
        .index  (pick_idx)
    );

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            grant_out     <= '0;
            grant_idx     <= '0;
            rr_ptr        <= '0;
            blk_count     <= '0;
            mul_n_out     <= '0;
            mul_m_out     <= '0;
            mul_valid_out <= 1'b0;
            data_out      <= '0;
            valid_out     <= '0;
            final_out     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mul_valid_out <= 1'b0;
                    valid_out     <= '0;
                    final_out     <= '0;
                    if ((|req_in) && mul_ready_in) begin
                        grant_out <= pick_onehot;
                        grant_idx <= pick_idx;
                        blk_count <= '0;
                        state     <= FEED;
                    end
                end
                FEED: begin
                    mul_n_out     <= n_in[grant_idx*REGISTER_SIZE +: REGISTER_SIZE];
                    mul_m_out     <= m_in[grant_idx*REGISTER_SIZE +: REGISTER_SIZE];
                    mul_valid_out <= blk_valid_in[grant_idx];
                    if (blk_valid_in[grant_idx]) begin
                        blk_count <= blk_count + 1'b1;
                        if (blk_count == COUNT_WIDTH'(BLOCKS - 1)) begin
                            grant_out <= '0;
                            state     <= WAIT_RESULT;
                        end
                    end
                end
                WAIT_RESULT: begin
                    mul_valid_out <= 1'b0;
                    data_out      <= mul_data_in;
                    valid_out     <= NUM_REQ'(mul_valid_in) << grant_idx;
                    final_out     <= NUM_REQ'(mul_final_in) << grant_idx;
                    if (mul_final_in) begin
                        rr_ptr <= grant_idx;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiplier_arbiter.sv
// ============================================================================
// tb_multiplier_arbiter : directed self-checking bench with a multiplier model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier_arbiter;

    localparam int RS   = 32;
    localparam int BITS = 4096;
    localparam int NR   = 4;
    localparam int BLK  = BITS / RS;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic [NR-1:0]       req_in;
    logic [NR*RS-1:0]    n_in;
    logic [NR*RS-1:0]    m_in;
    logic [NR-1:0]       blk_valid_in;
    logic [NR-1:0]       grant_out;
    logic [RS-1:0]       mul_n_out;
    logic [RS-1:0]       mul_m_out;
    logic                mul_valid_out;
    logic                mul_ready_in;
    logic [RS-1:0]       mul_data_in;
    logic                mul_valid_in;
    logic                mul_final_in;
    logic [RS-1:0]       data_out;
    logic [NR-1:0]       valid_out;
    logic [NR-1:0]       final_out;
    logic                busy_out;

    int checks = 0;
    int errors = 0;

    multiplier_arbiter #(
        .REGISTER_SIZE (RS),
        .BITS_IN_NUM   (BITS),
        .NUM_REQ       (NR)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_in        (req_in),
        .n_in          (n_in),
        .m_in          (m_in),
        .blk_valid_in  (blk_valid_in),
        .grant_out     (grant_out),
        .mul_n_out     (mul_n_out),
        .mul_m_out     (mul_m_out),
        .mul_valid_out (mul_valid_out),
        .mul_ready_in  (mul_ready_in),
        .mul_data_in   (mul_data_in),
        .mul_valid_in  (mul_valid_in),
        .mul_final_in  (mul_final_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .final_out     (final_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Block-serial multiplier model: collects BLK n/m blocks, then streams 2*BLK product blocks
    logic [BITS-1:0]   acc_n, acc_m;
    logic [2*BITS-1:0] prod;
    int                mcnt, ocnt;
    logic              streaming;
    logic              hold_not_ready;

    assign mul_ready_in = !streaming && (mcnt == 0) && !hold_not_ready;

    always @(posedge clk_in) begin
        if (rst_in) begin
            mcnt         <= 0;
            ocnt         <= 0;
            streaming    <= 1'b0;
            mul_valid_in <= 1'b0;
            mul_final_in <= 1'b0;
            mul_data_in  <= '0;
        end else if (!streaming) begin
            mul_valid_in <= 1'b0;
            mul_final_in <= 1'b0;
            if (mul_valid_out) begin
                acc_n[mcnt*RS +: RS] <= mul_n_out;
                acc_m[mcnt*RS +: RS] <= mul_m_out;
                if (mcnt == BLK - 1) begin
                    mcnt      <= 0;
                    ocnt      <= 0;
                    streaming <= 1'b1;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end else begin
            if (ocnt == 0) prod = {{BITS{1'b0}}, acc_n} * {{BITS{1'b0}}, acc_m};
            mul_data_in  <= prod[ocnt*RS +: RS];
            mul_valid_in <= 1'b1;
            mul_final_in <= (ocnt == 2*BLK - 1);
            if (ocnt == 2*BLK - 1) streaming <= 1'b0;
            ocnt <= ocnt + 1;
        end
    end

    function automatic logic [31:0] oh(input int r);
        logic [31:0] v;
        v = 32'd1;
        return v << r;
    endfunction

    function automatic logic [31:0] exp_block(input int beat, input logic [31:0] exp0, input bit ones);
        if (ones) begin
            if (beat == 0)        return 32'h0000_0001;
            else if (beat < 128)  return 32'h0000_0000;
            else if (beat == 128) return 32'hFFFF_FFFE;
            else                  return 32'hFFFF_FFFF;
        end
        return (beat == 0) ? exp0 : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_grant(input int r);
        for (int c = 0; c < 300; c++) begin
            if (grant_out != '0) break;
            tick();
        end
        chk("grant", 32'(grant_out), oh(r));
    endtask

    task automatic feed(input int r, input int nblk, input logic [31:0] nb0,
                        input logic [31:0] mb0, input bit ones, input int gap_at);
        for (int j = 0; j < NR; j++) begin
            if (j != r) begin
                n_in[j*RS +: RS] = 32'hDEAD_0000 | 32'(j);
                m_in[j*RS +: RS] = 32'hBEEF_0000 | 32'(j);
            end
        end
        for (int b = 0; b < nblk; b++) begin
            if (b == gap_at) begin
                blk_valid_in[r] = 1'b0;
                for (int g = 0; g < 10; g++) begin
                    tick();
                    if (g == 5) begin
                        chk("gap_mul_valid", 32'(mul_valid_out), 32'h0);
                        chk("gap_grant", 32'(grant_out), oh(r));
                    end
                end
            end
            if (ones) begin
                n_in[r*RS +: RS] = 32'hFFFF_FFFF;
                m_in[r*RS +: RS] = 32'hFFFF_FFFF;
            end else if (b == 0) begin
                n_in[r*RS +: RS] = nb0;
                m_in[r*RS +: RS] = mb0;
            end else begin
                n_in[r*RS +: RS] = 32'h0;
                m_in[r*RS +: RS] = 32'h0;
            end
            blk_valid_in = '1;
            tick();
        end
        blk_valid_in = '0;
    endtask

    task automatic collect(input int r, input logic [31:0] exp0, input bit ones);
        int  beat;
        bit  done;
        beat = 0;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (valid_out != '0 || final_out != '0) begin
                chk("valid_onehot", 32'(valid_out), oh(r));
                chk("data", data_out, exp_block(beat, exp0, ones));
                if (final_out != '0) begin
                    chk("final_onehot", 32'(final_out), oh(r));
                    chk("final_beat", 32'(beat), 32'd255);
                    done = 1'b1;
                end
                beat++;
            end
        end
        chk("final_seen", 32'(done), 32'h1);
    endtask

    task automatic run_job(input int r, input logic [31:0] nb0, input logic [31:0] mb0,
                           input logic [31:0] exp0, input bit ones, input int gap_at);
        wait_grant(r);
        feed(r, BLK, nb0, mb0, ones, gap_at);
        chk("grant_drop", 32'(grant_out), 32'h0);
        chk("busy_wait", 32'(busy_out), 32'h1);
        collect(r, exp0, ones);
    endtask

    logic [31:0] exp3 [4] = '{32'd14, 32'd21, 32'd28, 32'd35};

    initial begin
        rst_in         = 1'b1;
        req_in         = '0;
        n_in           = '0;
        m_in           = '0;
        blk_valid_in   = '0;
        hold_not_ready = 1'b0;
        tick(); tick(); tick();
        rst_in = 1'b0;
        chk("rst_grant", 32'(grant_out), 32'h0);
        chk("rst_busy", 32'(busy_out), 32'h0);
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_final", 32'(final_out), 32'h0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_mul_valid", 32'(mul_valid_out), 32'h0);

        // Single requester: 3 * 5
        req_in = 4'b0001;
        run_job(0, 32'd3, 32'd5, 32'd15, 1'b0, -1);

        // Round-robin ordering from rr_ptr = 0
        req_in = 4'b0110;
        run_job(1, 32'd9, 32'd9, 32'd81, 1'b0, -1);
        run_job(2, 32'd10, 32'd3, 32'd30, 1'b0, -1);
        req_in = 4'b0011;
        run_job(0, 32'd100, 32'd2, 32'd200, 1'b0, -1);
        run_job(1, 32'd1000, 32'd1000, 32'd1000000, 1'b0, -1);

        // Grant withheld while multiplier not ready
        req_in         = 4'b1000;
        hold_not_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("no_grant_not_ready", 32'(grant_out), 32'h0);
        end
        hold_not_ready = 1'b0;
        tick();
        chk("grant_after_ready", 32'(grant_out), 32'h8);
        run_job(3, 32'd3, 32'd5, 32'd15, 1'b0, -1);

        // All four requesting continuously
        req_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            run_job(i % 4, 32'((i % 4) + 2), 32'd7, exp3[i % 4], 1'b0, -1);
        end

        // All-ones operands with a 10-cycle gap after block 50
        req_in = 4'b0100;
        run_job(2, 32'h0, 32'h0, 32'h0, 1'b1, 51);

        // Reset in the middle of FEED
        req_in = 4'b0001;
        wait_grant(0);
        feed(0, 60, 32'h0, 32'h0, 1'b1, -1);
        chk("pre_rst_busy", 32'(busy_out), 32'h1);
        rst_in = 1'b1;
        req_in = '0;
        tick();
        rst_in = 1'b0;
        chk("mid_rst_grant", 32'(grant_out), 32'h0);
        chk("mid_rst_mul_valid", 32'(mul_valid_out), 32'h0);
        chk("mid_rst_mul_n", mul_n_out, 32'h0);
        chk("mid_rst_mul_m", mul_m_out, 32'h0);
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_valid", 32'(valid_out), 32'h0);
        chk("mid_rst_final", 32'(final_out), 32'h0);
        chk("mid_rst_busy", 32'(busy_out), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("post_rst_no_final", 32'(final_out), 32'h0);
        end
        req_in = 4'b0001;
        run_job(0, 32'd3, 32'd5, 32'd15, 1'b0, -1);
        req_in = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
